// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: response-owner encoding and default bus widths.
package sram_port_arbiter_pkg;

  localparam int SRAM_AW = 32;
  localparam int SRAM_DW = 32;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Fetch/EX request buses plus the SRAM port; slave = arbiter side, master = requesters and SRAM.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
);
  logic              inst_req;
  logic [AW-1:0]     inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DW-1:0]     inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [DW/8-1:0]   data_wstrb;
  logic [AW-1:0]     data_addr;
  logic [DW-1:0]     data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DW-1:0]     data_rdata;

  logic              sram_en;
  logic [DW/8-1:0]   sram_wen;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_port_arbiter_starve.sv
// Inst-starvation counter: counts data wins while fetch waits, raises force_inst at STARVE_MAX.
// Clears on any inst grant or when fetch drops its request.
module sram_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic inst_gnt,
  input  logic data_gnt,
  output logic force_inst
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_gnt) begin
      starve_cnt <= '0;
    end else if (data_gnt) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign force_inst = (starve_cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM shared by fetch and EX; data has priority, responses return exactly 1 cycle after addr_ok.
// Optional fetch starvation guard under `SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW         = SRAM_AW,
  parameter int DW         = SRAM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus
);

  logic            gnt_inst;
  logic            gnt_data;
  logic            force_inst;
  logic [AW-1:0]   addr_mux;
  logic [DW/8-1:0] wen_mux;
  resp_owner_e     resp_owner;
  resp_owner_e     resp_owner_nxt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  sram_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .inst_req   (bus.inst_req),
    .inst_gnt   (gnt_inst),
    .data_gnt   (gnt_data),
    .force_inst (force_inst)
  );
`else
  logic starve_max_unused;
  assign starve_max_unused = |STARVE_MAX;
  assign force_inst        = 1'b0;
`endif

  // Forced fetch only steals the slot when fetch is actually asking.
  assign gnt_data = bus.data_req && !(force_inst && bus.inst_req);
  assign gnt_inst = bus.inst_req && !gnt_data;

  assign bus.inst_addr_ok = gnt_inst;
  assign bus.data_addr_ok = gnt_data;

  assign addr_mux = gnt_data ? bus.data_addr : bus.inst_addr;
  assign wen_mux  = (gnt_data && bus.data_wr) ? bus.data_wstrb : '0;

  assign bus.sram_en    = gnt_inst || gnt_data;
  assign bus.sram_wen   = wen_mux;
  assign bus.sram_addr  = addr_mux;
  assign bus.sram_wdata = bus.data_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner <= RESP_NONE;
    end else begin
      resp_owner <= resp_owner_nxt;
    end
  end

  always_comb begin
    resp_owner_nxt = RESP_NONE;
    if (gnt_data) begin
      resp_owner_nxt = RESP_DATA;
    end else if (gnt_inst) begin
      resp_owner_nxt = RESP_INST;
    end
  end

  // Gated by reset so a response in flight is dropped even while reset is held.
  assign bus.inst_data_ok = (resp_owner == RESP_INST) && !reset;
  assign bus.data_data_ok = (resp_owner == RESP_DATA) && !reset;
  assign bus.inst_rdata   = bus.sram_rdata;
  assign bus.data_rdata   = bus.sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle SRAM; guard scenario follows SRAM_ARB_STARVE_GUARD_EN.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  sram_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:4095];

  // SRAM model: preload during reset, byte-strobed write, registered read.
  always @(posedge clk) begin
    if (reset) begin
      mem[12'h040] <= 32'h1234_5678;
      mem[12'h041] <= 32'h9ABC_DEF0;
      mem[12'h042] <= 32'h0F0F_0F0F;
      mem[12'h800] <= 32'hDEAD_0001;
      mem[12'h801] <= 32'h1122_3344;
    end else if (bus.sram_en) begin
      if (bus.sram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_wen[b]) mem[bus.sram_addr[13:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr[13:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.inst_req  = 1'b1;
    bus.inst_addr = a;
  endtask

  task automatic load(input logic [31:0] a);
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = 4'b0000;
    bus.data_addr  = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] fetch_addr [3];
  logic [31:0] fetch_word [3];
  bit          exp_inst_win;
  bit          prev_data;

  initial begin
    fetch_addr[0] = 32'h100; fetch_word[0] = 32'h1234_5678;
    fetch_addr[1] = 32'h104; fetch_word[1] = 32'h9ABC_DEF0;
    fetch_addr[2] = 32'h108; fetch_word[2] = 32'h0F0F_0F0F;

    // Reset state
    reset = 1'b1;
    bus.sram_rdata = '0;
    idle();
    tick();
    tick();
    mid();
    chk("rst_inst_data_ok", bus.inst_data_ok, 0);
    chk("rst_data_data_ok", bus.data_data_ok, 0);
    chk("rst_sram_en",      bus.sram_en, 0);
    tick();
    reset = 1'b0;
    mid();
    chk("post_rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);

    // Single fetch
    tick();
    fetch(32'h100);
    mid();
    chk("f1_inst_addr_ok", bus.inst_addr_ok, 1);
    chk("f1_data_addr_ok", bus.data_addr_ok, 0);
    chk("f1_sram_en",      bus.sram_en, 1);
    chk("f1_sram_wen",     bus.sram_wen, 0);
    chk("f1_sram_addr",    bus.sram_addr, 32'h100);
    tick();
    idle();
    mid();
    chk("f1_inst_data_ok", bus.inst_data_ok, 1);
    chk("f1_inst_rdata",   bus.inst_rdata, 32'h1234_5678);
    chk("f1_data_data_ok", bus.data_data_ok, 0);

    // Simultaneous fetch and load: data first, fetch follows
    tick();
    fetch(32'h100);
    load(32'h2000);
    mid();
    chk("cf_c0_data_addr_ok", bus.data_addr_ok, 1);
    chk("cf_c0_inst_addr_ok", bus.inst_addr_ok, 0);
    chk("cf_c0_sram_addr",    bus.sram_addr, 32'h2000);
    tick();
    bus.data_req = 1'b0;
    mid();
    chk("cf_c1_data_data_ok", bus.data_data_ok, 1);
    chk("cf_c1_data_rdata",   bus.data_rdata, 32'hDEAD_0001);
    chk("cf_c1_inst_addr_ok", bus.inst_addr_ok, 1);
    tick();
    idle();
    mid();
    chk("cf_c2_inst_data_ok", bus.inst_data_ok, 1);
    chk("cf_c2_inst_rdata",   bus.inst_rdata, 32'h1234_5678);
    chk("cf_c2_data_data_ok", bus.data_data_ok, 0);

    // Partial store then read back
    tick();
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_wstrb = 4'b0011;
    bus.data_addr  = 32'h2004;
    bus.data_wdata = 32'hAABB_CCDD;
    mid();
    chk("st_sram_wen",   bus.sram_wen, 4'b0011);
    chk("st_sram_addr",  bus.sram_addr, 32'h2004);
    chk("st_sram_wdata", bus.sram_wdata, 32'hAABB_CCDD);
    tick();
    idle();
    mid();
    chk("st_data_data_ok", bus.data_data_ok, 1);
    tick();
    load(32'h2004);
    mid();
    chk("ld_sram_wen", bus.sram_wen, 0);
    tick();
    idle();
    mid();
    chk("ld_data_rdata", bus.data_rdata, 32'h1122_CCDD);

    // Three back-to-back fetches
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) fetch(fetch_addr[i]);
      else       idle();
      mid();
      if (i < 3) chk($sformatf("b2b_addr_ok_%0d", i), bus.inst_addr_ok, 1);
      if (i > 0) begin
        chk($sformatf("b2b_data_ok_%0d", i), bus.inst_data_ok, 1);
        chk($sformatf("b2b_rdata_%0d", i),   bus.inst_rdata, fetch_word[i-1]);
      end
      tick();
    end

    // Reset while a load response is pending
    load(32'h2000);
    mid();
    chk("rm_data_addr_ok", bus.data_addr_ok, 1);
    tick();
    idle();
    reset = 1'b1;
    mid();
    chk("rm_rst_data_ok", bus.data_data_ok, 0);
    tick();
    reset = 1'b0;
    mid();
    chk("rm_after_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);

    // Fetch withdrawn before it is accepted leaves nothing behind
    tick();
    fetch(32'h104);
    load(32'h2000);
    mid();
    chk("wd_inst_addr_ok", bus.inst_addr_ok, 0);
    tick();
    idle();
    mid();
    chk("wd_c1_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b01);
    tick();
    mid();
    chk("wd_c2_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);

    // Both requesters held: strict priority, or fetch forced in cycle 4 with the guard
    tick();
    fetch(32'h100);
    load(32'h2000);
    prev_data = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
      exp_inst_win = (i == 4);
`else
      exp_inst_win = 1'b0;
`endif
      mid();
      chk($sformatf("hold_inst_addr_ok_%0d", i), bus.inst_addr_ok, exp_inst_win);
      chk($sformatf("hold_data_addr_ok_%0d", i), bus.data_addr_ok, !exp_inst_win);
      if (i > 0) chk($sformatf("hold_data_data_ok_%0d", i), bus.data_data_ok, prev_data);
      prev_data = !exp_inst_win;
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
